// File: rtl/sb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sb_mem_slave
//  Purpose  : System-bus memory responder. Accepts one read/write request at
//             a time, waits WAIT_CYCLES, performs the access on an internal
//             byte-lane RAM and returns a one-cycle response pulse.
//  Ports    : clk, rst (async, active-low)
//             s_req / s_rw / s_addr / s_wdata / s_byte_mask : request in
//             s_ready_o  : request can be accepted this cycle
//             s_rvalid_o : one-cycle response pulse
//             s_rdata_o  : raw addressed word (0 for writes and errors)
//             s_err_o    : error flag, valid with s_rvalid_o
//  Revision : 1.0  initial release
// ============================================================================
module sb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req,
  input  logic                  s_rw,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [3:0]            s_byte_mask,
  output logic                  s_ready_o,
  output logic                  s_rvalid_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic                  s_err_o
);

  localparam int        IDX_W     = $clog2(DEPTH_WORDS);
  localparam int        LANE_W    = DATA_WIDTH / 4;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      idx;
  logic [3:0]            lane_en;
  logic [DATA_WIDTH-1:0] ram_word;
  logic                  out_of_range;
  logic                  mask_bad;
  logic                  half_mis;
  logic                  word_mis;
  logic                  acc_err;
  logic                  wr_en;

  // --------------------------------------------------------------------------
  // Access decode on the latched request
  // --------------------------------------------------------------------------
  assign idx      = addr_q[IDX_W+1:2];
  // Mask is sent unshifted; move it onto the addressed lanes.
  assign lane_en  = 4'(mask_q << addr_q[1:0]);
  assign mask_bad = !((mask_q == 4'b0001) || (mask_q == 4'b0011) || (mask_q == 4'b1111));
  assign half_mis = (mask_q == 4'b0011) && addr_q[0];
  assign word_mis = (mask_q == 4'b1111) && (addr_q[1:0] != 2'b00);
  assign acc_err  = mask_bad || half_mis || word_mis || out_of_range;
  assign wr_en    = (state_q == ST_ACCESS) && rw_q && !acc_err;

  // DEPTH_WORDS is a power of two, so any address bit above the index field
  // being set means the word is past the end of the RAM.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_range
    assign out_of_range = |addr_q[ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Storage: one byte-wide array per lane so partial writes need no
  // read-modify-write. Contents are intentionally not reset.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [LANE_W-1:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en && lane_en[g]) begin
        ram[idx] <= wdata_q[LANE_W*g +: LANE_W];
      end
    end

    assign ram_word[LANE_W*g +: LANE_W] = ram[idx];
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (s_req) begin
          rw_d    = s_rw;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          mask_d  = s_byte_mask;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        // Counter was loaded with WAIT_CYCLES, so leaving at 1 spends
        // exactly WAIT_CYCLES cycles here.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        err_d   = acc_err;
        rdata_d = (!acc_err && !rw_q) ? ram_word : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_ready_o  = (state_q == ST_IDLE);
  assign s_rvalid_o = (state_q == ST_RESP);
  assign s_err_o    = (state_q == ST_RESP) && err_q;
  assign s_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sb_mem_slave
//  Purpose  : Self-checking bench for sb_mem_slave. Three instances with
//             WAIT_CYCLES = 1, 0, 4 share clk/rst; a byte-addressed reference
//             memory per instance predicts error, data and latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sb_mem_slave;

  localparam int NDUT  = 3;
  localparam int DEPTH = 1024;
  localparam int WAITS [NDUT] = '{1, 0, 4};

  logic                 clk;
  logic                 rst;
  logic [NDUT-1:0]      req;
  logic [NDUT-1:0]      rw;
  logic [NDUT-1:0][31:0] addr;
  logic [NDUT-1:0][31:0] wdata;
  logic [NDUT-1:0][3:0]  mask;
  logic [NDUT-1:0]      ready_o;
  logic [NDUT-1:0]      rvalid_o;
  logic [NDUT-1:0][31:0] rdata_o;
  logic [NDUT-1:0]      err_o;

  int n_checks;
  int n_errors;

  // Reference memory: bytes, with a per-word "written" flag.
  logic [7:0] ref_mem [NDUT][DEPTH][4];
  bit         known   [NDUT][DEPTH];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sb_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(WAITS[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .s_req      (req[g]),
      .s_rw       (rw[g]),
      .s_addr     (addr[g]),
      .s_wdata    (wdata[g]),
      .s_byte_mask(mask[g]),
      .s_ready_o  (ready_o[g]),
      .s_rvalid_o (rvalid_o[g]),
      .s_rdata_o  (rdata_o[g]),
      .s_err_o    (err_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  function automatic int access_size(input logic [3:0] m);
    case (m)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [3:0] m);
    int sz = access_size(m);
    if (sz == 0)              return 1'b1;
    if ((a % sz) != 0)        return 1'b1;
    if ((a / 4) >= DEPTH)     return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int w = int'(a / 4);
    return {ref_mem[d][w][3], ref_mem[d][w][2], ref_mem[d][w][1], ref_mem[d][w][0]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] m);
    int sz = access_size(m);
    int w  = int'(a / 4);
    for (int j = 0; j < sz; j++) begin
      int lane = int'((a + j) % 4);
      ref_mem[d][w][lane] = wd[8*lane +: 8];
    end
    if (sz == 4) known[d][w] = 1'b1;
  endtask

  // ---- one complete transaction with latency/pulse/result checks ---------
  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic e, output logic [31:0] rd);
    int  guard;
    int  cyc;
    bit  exp_e;
    logic [31:0] exp_d;
    e  = 1'b0;
    rd = '0;
    @(negedge clk);
    req[d] = 1'b1; rw[d] = w; addr[d] = a; wdata[d] = wd; mask[d] = m;
    guard = 0;
    while (!ready_o[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("ready_timeout", 32'(ready_o[d]), 32'd1);
      req[d] = 1'b0;
      return;
    end
    // Accepted at the next rising edge; this is cycle 0.
    cyc = 0;
    @(negedge clk);
    req[d] = 1'b0;
    cyc = 1;
    while (!rvalid_o[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) begin
      check("rvalid_timeout", 32'(rvalid_o[d]), 32'd1);
      return;
    end
    check($sformatf("latency_d%0d", d), 32'(cyc), 32'(WAITS[d] + 2));
    check("ready_low_in_resp", 32'(ready_o[d]), 32'd0);
    e  = err_o[d];
    rd = rdata_o[d];

    exp_e = model_err(a, m);
    exp_d = 32'd0;
    if (!exp_e && !w) exp_d = model_word(d, a);
    check($sformatf("err_%s_%h_m%b", w ? "wr" : "rd", a, m), 32'(e), 32'(exp_e));
    if (exp_e || w || known[d][int'(a / 4)])
      check($sformatf("rdata_%s_%h", w ? "wr" : "rd", a), rd, exp_d);
    if (!exp_e && w) model_write(d, a, wd, m);

    @(negedge clk);
    check("rvalid_single_pulse", 32'(rvalid_o[d]), 32'd0);
    check("err_low_after_resp", 32'(err_o[d]), 32'd0);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_ready"},  32'(ready_o[d]),  32'd1);
    check({tag, "_rvalid"}, 32'(rvalid_o[d]), 32'd0);
    check({tag, "_rdata"},  rdata_o[d],       32'd0);
    check({tag, "_err"},    32'(err_o[d]),    32'd0);
  endtask

  // ---- stimulus ------------------------------------------------------------
  initial begin
    logic        e;
    logic [31:0] rd;
    logic [3:0]  masks [4];
    int          pulses;
    int          accepts;
    int          last;
    logic        prev_ready;

    n_checks = 0;
    n_errors = 0;
    req = '0; rw = '0; addr = '0; wdata = '0; mask = '0;
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < DEPTH; w++) known[d][w] = 1'b0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_reset_outputs(d, "reset");
    rst = 1'b1;
    @(negedge clk);

    // Word write then read (WAIT_CYCLES = 1).
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, e, rd);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, e, rd);
    check("word_readback", rd, 32'hDEADBEEF);

    // Byte and half lanes.
    do_txn(0, 1'b1, 32'h20, 32'h00000000, 4'b1111, e, rd);
    do_txn(0, 1'b1, 32'h22, 32'h00AB0000, 4'b0001, e, rd);
    do_txn(0, 1'b1, 32'h20, 32'h00001234, 4'b0011, e, rd);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'b1111, e, rd);
    check("lane_merge", rd, 32'h00AB1234);

    // Misaligned / illegal.
    do_txn(0, 1'b0, 32'h21, 32'h0, 4'b1111, e, rd);
    check("misaligned_word_err", 32'(e), 32'd1);
    do_txn(0, 1'b1, 32'h23, 32'hFFFFFFFF, 4'b0011, e, rd);
    check("misaligned_half_err", 32'(e), 32'd1);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'b1111, e, rd);
    check("unchanged_after_err", rd, 32'h00AB1234);
    do_txn(0, 1'b1, 32'h30, 32'h12345678, 4'b0111, e, rd);
    check("illegal_mask_err", 32'(e), 32'd1);

    // Range boundary.
    do_txn(0, 1'b0, 32'h1000, 32'h0, 4'b1111, e, rd);
    check("out_of_range_err", 32'(e), 32'd1);
    do_txn(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, e, rd);
    do_txn(0, 1'b0, 32'hFFC, 32'h0, 4'b1111, e, rd);
    check("last_word_ok", 32'(e), 32'd0);
    check("last_word_data", rd, 32'hCAFEF00D);

    // Randomised traffic over a small window plus out-of-range addresses.
    for (int w = 0; w < 8; w++)
      do_txn(0, 1'b1, 32'(4 * w), $urandom, 4'b1111, e, rd);
    masks = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  m;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      m = masks[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) == 0) m = 4'($urandom);
      do_txn(0, 1'($urandom), a, $urandom, m, e, rd);
    end

    // Zero wait states with s_req held high: four back-to-back reads.
    do_txn(1, 1'b1, 32'h10, 32'hA5A55A5A, 4'b1111, e, rd);
    @(negedge clk);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h10; mask[1] = 4'b1111;
    pulses = 0; accepts = 0; last = -1; prev_ready = 1'b1;
    for (int c = 0; c < 40 && pulses < 4; c++) begin
      if (rvalid_o[1]) begin
        if (last >= 0) check("busy_spacing", 32'(c - last), 32'd3);
        last = c;
        pulses++;
        check("busy_rdata", rdata_o[1], 32'hA5A55A5A);
        check("busy_ready_low_access", 32'(prev_ready), 32'd0);
      end
      if (accepts == 4) req[1] = 1'b0;
      if (ready_o[1] && req[1]) accepts++;
      prev_ready = ready_o[1];
      @(negedge clk);
    end
    req[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid_o[1]) pulses++;
      @(negedge clk);
    end
    check("busy_pulse_count", 32'(pulses), 32'd4);

    // Reset in the middle of a WAIT_CYCLES = 4 write.
    do_txn(2, 1'b1, 32'h40, 32'h11111111, 4'b1111, e, rd);
    do_txn(2, 1'b0, 32'h40, 32'h0, 4'b1111, e, rd);
    check("pre_abort_read", rd, 32'h11111111);
    @(negedge clk);
    req[2] = 1'b1; rw[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h55555555; mask[2] = 4'b1111;
    @(negedge clk);
    req[2] = 1'b0;
    check("abort_in_wait_busy", 32'(ready_o[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs(2, "abort");
    @(negedge clk);
    rst = 1'b1;
    do_txn(2, 1'b0, 32'h40, 32'h0, 4'b1111, e, rd);
    check("abort_keeps_old", rd, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
